// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 encodings, ALU functions and condition evaluation
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                       input logic sf, input logic of);
        logic res;
        case (fn)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/y86_fde_core_if.sv
// rtl/y86_fde_core_if.sv - instruction, write-back and decoded-result bundle of the front end
interface y86_fde_core_if;
    logic [63:0] pc;
    logic [79:0] imem_bytes;
    logic [3:0]  wb_dstE;
    logic [3:0]  wb_dstM;
    logic [63:0] wb_valE;
    logic [63:0] wb_valM;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cnd;
    logic        imem_error;
    logic        instr_valid;
    logic        halt;

    modport master (
        output pc, imem_bytes, wb_dstE, wb_dstM, wb_valE, wb_valM,
        input  icode, ifun, rA, rB, valC, valP, valA, valB, valE,
        input  zf, sf, of, cnd, imem_error, instr_valid, halt
    );

    modport slave (
        input  pc, imem_bytes, wb_dstE, wb_dstM, wb_valE, wb_valM,
        output icode, ifun, rA, rB, valC, valP, valA, valB, valE,
        output zf, sf, of, cnd, imem_error, instr_valid, halt
    );
endinterface

// File: rtl/y86_alu.sv
// rtl/y86_alu.sv - 64-bit Y86 ALU computing b OP a with zero/sign/overflow flags
module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  alu_fn_e     fn,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fn)
            ALU_ADD: begin
                result = b + a;
                of     = (a[63] == b[63]) && (result[63] != b[63]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[63] != b[63]) && (result[63] != b[63]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = '0;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];

endmodule

// File: rtl/y86_fde_core.sv
// rtl/y86_fde_core.sv - single-cycle Y86-64 fetch/decode/execute with register file and CC; optional Y86_INVALID_INSN_EN
module y86_fde_core
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input logic           clk,
    input logic           rst,
    y86_fde_core_if.slave bus
);

    localparam logic [63:0] PC_LIMIT = 64'(IMEM_BYTES - 10);

    logic [7:0]  b0, b1;
    logic        imem_error, need_regids, need_valc, instr_valid, halt, cnd;
    logic [3:0]  icode, ifun, ra, rb, src_a, src_b;
    logic [63:0] val_c, val_p, val_a, val_b, val_e;
    logic [63:0] alu_a, alu_b, alu_res;
    alu_fn_e     alu_fn;
    logic        alu_zf, alu_sf, alu_of;
    logic        zf_q, sf_q, of_q;
    logic [63:0] regs [0:14];

    assign b0          = bus.imem_bytes[7:0];
    assign b1          = bus.imem_bytes[15:8];
    assign imem_error  = (bus.pc > PC_LIMIT);
    assign icode       = imem_error ? I_NOP : b0[7:4];
    assign ifun        = b0[3:0];
    assign need_regids = icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                       I_OPQ, I_PUSHQ, I_POPQ};
    assign need_valc   = icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    assign ra          = need_regids ? b1[7:4] : R_NONE;
    assign rb          = need_regids ? b1[3:0] : R_NONE;
    assign val_c       = need_regids ? bus.imem_bytes[79:16] : bus.imem_bytes[71:8];
    assign val_p       = bus.pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);

`ifdef Y86_INVALID_INSN_EN
    always_comb begin
        instr_valid = 1'b1;
        if (icode > I_POPQ)
            instr_valid = 1'b0;
        else if ((icode == I_RRMOVQ || icode == I_JXX) && ifun > 4'd6)
            instr_valid = 1'b0;
        else if (icode == I_OPQ && ifun > 4'd3)
            instr_valid = 1'b0;
    end
`else
    assign instr_valid = 1'b1;
`endif

    assign halt = (icode == I_HALT) | imem_error | ~instr_valid;

    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = ra;
            I_RET, I_POPQ:                      src_a = R_RSP;
            default:                            src_a = R_NONE;
        endcase
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ: src_b = rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:      src_b = R_RSP;
            default:                             src_b = R_NONE;
        endcase
    end

    assign val_a = (src_a == R_NONE) ? 64'd0 : regs[src_a];
    assign val_b = (src_b == R_NONE) ? 64'd0 : regs[src_b];

    // Stack and address arithmetic reuse the ALU adder; opq selects the function from ifun.
    always_comb begin
        alu_a  = 64'd8;
        alu_b  = val_b;
        alu_fn = ALU_ADD;
        case (icode)
            I_RMMOVQ, I_MRMOVQ: alu_a = val_c;
            I_OPQ: begin
                alu_a  = val_a;
                alu_fn = alu_fn_e'(ifun[1:0]);
            end
            I_CALL, I_PUSHQ:    alu_fn = ALU_SUB;
            default:            alu_a = 64'd8;
        endcase
    end

    y86_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    always_comb begin
        val_e = 64'd0;
        case (icode)
            I_RRMOVQ: val_e = val_a;
            I_IRMOVQ: val_e = val_c;
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: val_e = alu_res;
            default:  val_e = 64'd0;
        endcase
        if (!instr_valid)
            val_e = 64'd0;
    end

    assign cnd = (icode == I_RRMOVQ || icode == I_JXX) ? cond_eval(ifun, zf_q, sf_q, of_q) : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (icode == I_OPQ && !halt) begin
            zf_q <= alu_zf;
            sf_q <= alu_sf;
            of_q <= alu_of;
        end
    end

    // The M port has priority when both write ports name the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= 64'd0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (bus.wb_dstM == 4'(i))
                    regs[i] <= bus.wb_valM;
                else if (bus.wb_dstE == 4'(i))
                    regs[i] <= bus.wb_valE;
            end
        end
    end

    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.rA          = ra;
    assign bus.rB          = rb;
    assign bus.valC        = val_c;
    assign bus.valP        = val_p;
    assign bus.valA        = val_a;
    assign bus.valB        = val_b;
    assign bus.valE        = val_e;
    assign bus.zf          = zf_q;
    assign bus.sf          = sf_q;
    assign bus.of          = of_q;
    assign bus.cnd         = cnd;
    assign bus.imem_error  = imem_error;
    assign bus.instr_valid = instr_valid;
    assign bus.halt        = halt;

endmodule

// File: tb/tb_y86_fde_core.sv
// tb/tb_y86_fde_core.sv - directed vector bench for y86_fde_core
module tb_y86_fde_core;

    localparam int IMEM = 1024;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    y86_fde_core_if bus ();

    y86_fde_core #(.IMEM_BYTES(IMEM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, vala, valb, vale;
        logic        cnd, halt, err, valid;
    } vec_t;

    vec_t vt[$];

    function automatic logic [79:0] enc(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [63:0] c, input bit regs);
        if (regs)
            return {c, b1, b0};
        return {8'h00, c, b0};
    endfunction

    function automatic vec_t mkv(input logic [63:0] pc, input logic [79:0] bytes,
                                 input logic [3:0] icode, input logic [3:0] ifun,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [63:0] valc, input logic [63:0] valp,
                                 input logic [63:0] vala, input logic [63:0] valb,
                                 input logic [63:0] vale, input logic cnd,
                                 input logic halt, input logic err, input logic valid);
        vec_t v;
        v.pc = pc; v.bytes = bytes; v.icode = icode; v.ifun = ifun; v.ra = ra; v.rb = rb;
        v.valc = valc; v.valp = valp; v.vala = vala; v.valb = valb; v.vale = vale;
        v.cnd = cnd; v.halt = halt; v.err = err; v.valid = valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [63:0] pc, input logic [79:0] bytes);
        @(negedge clk);
        bus.pc = pc;
        bus.imem_bytes = bytes;
        #1;
    endtask

    task automatic wr(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        @(negedge clk);
        bus.wb_dstE = de; bus.wb_valE = ve;
        bus.wb_dstM = dm; bus.wb_valM = vm;
        @(posedge clk);
        #1;
        bus.wb_dstE = 4'hF;
        bus.wb_dstM = 4'hF;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.pc = 64'd0;
        bus.imem_bytes = enc(8'h10, 8'h00, 64'd0, 1'b0);
        bus.wb_dstE = 4'hF; bus.wb_dstM = 4'hF;
        bus.wb_valE = 64'd0; bus.wb_valM = 64'd0;
        #12;
        rst = 1'b0;

        // Dirty rax and the CC, then reset asynchronously mid-cycle.
        wr(4'h0, 64'd5, 4'hF, 64'd0);
        apply(64'd0, enc(8'h61, 8'h03, 64'd0, 1'b1));
        @(posedge clk); #1;
        chk("pre_rst_sf", {63'd0, bus.sf}, 64'd1);
        apply(64'd0, enc(8'h20, 8'h03, 64'd0, 1'b1));
        chk("pre_rst_rax", bus.valA, 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("rst_zf", {63'd0, bus.zf}, 64'd1);
        chk("rst_sf", {63'd0, bus.sf}, 64'd0);
        chk("rst_of", {63'd0, bus.of}, 64'd0);
        chk("rst_rax", bus.valA, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        wr(4'h0, MAXP, 4'h3, 64'd1);

        vt.push_back(mkv(64'd1, enc(8'h30, 8'hF3, 64'd10, 1'b1), 4'h3, 4'h0, 4'hF, 4'h3,
                         64'd10, 64'd11, 64'd0, 64'd1, 64'd10, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'd0, enc(8'h60, 8'h03, 64'd0, 1'b1), 4'h6, 4'h0, 4'h0, 4'h3,
                         64'd0, 64'd2, MAXP, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'h10, enc(8'h20, 8'h03, 64'd0, 1'b1), 4'h2, 4'h0, 4'h0, 4'h3,
                         64'd0, 64'h12, MAXP, 64'd0, MAXP, 1'b1, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'h20, enc(8'h50, 8'h03, 64'd8, 1'b1), 4'h5, 4'h0, 4'h0, 4'h3,
                         64'd8, 64'h2A, 64'd0, 64'd1, 64'd9, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'h30, enc(8'hA0, 8'h0F, 64'd0, 1'b1), 4'hA, 4'h0, 4'h0, 4'hF,
                         64'd0, 64'h32, MAXP, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'd5, enc(8'h70, 8'h00, 64'h100, 1'b0), 4'h7, 4'h0, 4'hF, 4'hF,
                         64'h100, 64'd14, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'h40, enc(8'h80, 8'h00, 64'h40, 1'b0), 4'h8, 4'h0, 4'hF, 4'hF,
                         64'h40, 64'h49, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'h50, enc(8'h90, 8'h00, 64'd0, 1'b0), 4'h9, 4'h0, 4'hF, 4'hF,
                         64'd0, 64'h51, 64'd0, 64'd0, 64'd8, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'h60, enc(8'h00, 8'h00, 64'd0, 1'b0), 4'h0, 4'h0, 4'hF, 4'hF,
                         64'd0, 64'h61, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        vt.push_back(mkv(64'(IMEM - 10), enc(8'h10, 8'h00, 64'd0, 1'b0), 4'h1, 4'h0, 4'hF, 4'hF,
                         64'd0, 64'(IMEM - 9), 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mkv(64'(IMEM - 9), enc(8'h30, 8'hF3, 64'd10, 1'b1), 4'h1, 4'h0, 4'hF, 4'hF,
                         64'h0AF3, 64'(IMEM - 8), 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1));
`ifdef Y86_INVALID_INSN_EN
        vt.push_back(mkv(64'd0, enc(8'hC0, 8'h00, 64'd0, 1'b0), 4'hC, 4'h0, 4'hF, 4'hF,
                         64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        vt.push_back(mkv(64'd0, enc(8'h27, 8'h03, 64'd0, 1'b1), 4'h2, 4'h7, 4'h0, 4'h3,
                         64'd0, 64'd2, MAXP, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        vt.push_back(mkv(64'd0, enc(8'h64, 8'h03, 64'd0, 1'b1), 4'h6, 4'h4, 4'h0, 4'h3,
                         64'd0, 64'd2, MAXP, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        vt.push_back(mkv(64'd0, enc(8'hC0, 8'h00, 64'd0, 1'b0), 4'hC, 4'h0, 4'hF, 4'hF,
                         64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1));
`endif

        foreach (vt[i]) begin
            apply(vt[i].pc, vt[i].bytes);
            chk($sformatf("v%0d_icode", i), {60'd0, bus.icode}, {60'd0, vt[i].icode});
            chk($sformatf("v%0d_ifun", i), {60'd0, bus.ifun}, {60'd0, vt[i].ifun});
            chk($sformatf("v%0d_rA", i), {60'd0, bus.rA}, {60'd0, vt[i].ra});
            chk($sformatf("v%0d_rB", i), {60'd0, bus.rB}, {60'd0, vt[i].rb});
            chk($sformatf("v%0d_valC", i), bus.valC, vt[i].valc);
            chk($sformatf("v%0d_valP", i), bus.valP, vt[i].valp);
            chk($sformatf("v%0d_valA", i), bus.valA, vt[i].vala);
            chk($sformatf("v%0d_valB", i), bus.valB, vt[i].valb);
            chk($sformatf("v%0d_valE", i), bus.valE, vt[i].vale);
            chk($sformatf("v%0d_cnd", i), {63'd0, bus.cnd}, {63'd0, vt[i].cnd});
            chk($sformatf("v%0d_halt", i), {63'd0, bus.halt}, {63'd0, vt[i].halt});
            chk($sformatf("v%0d_err", i), {63'd0, bus.imem_error}, {63'd0, vt[i].err});
            chk($sformatf("v%0d_valid", i), {63'd0, bus.instr_valid}, {63'd0, vt[i].valid});
        end

        // addq overflow sets of/sf and clears zf
        apply(64'd0, enc(8'h10, 8'h00, 64'd0, 1'b0));
        wr(4'h0, MAXP, 4'h3, 64'd1);
        apply(64'd0, enc(8'h60, 8'h03, 64'd0, 1'b1));
        chk("add_valE", bus.valE, 64'h8000_0000_0000_0000);
        @(posedge clk); #1;
        chk("add_of", {63'd0, bus.of}, 64'd1);
        chk("add_sf", {63'd0, bus.sf}, 64'd1);
        chk("add_zf", {63'd0, bus.zf}, 64'd0);
        apply(64'd0, enc(8'h72, 8'h00, 64'd0, 1'b0));
        chk("add_jl", {63'd0, bus.cnd}, 64'd0);
        apply(64'd0, enc(8'h76, 8'h00, 64'd0, 1'b0));
        chk("add_jg", {63'd0, bus.cnd}, 64'd1);

        // subq equal operands -> zero
        apply(64'd0, enc(8'h10, 8'h00, 64'd0, 1'b0));
        wr(4'h0, 64'd5, 4'h3, 64'd5);
        apply(64'd0, enc(8'h61, 8'h03, 64'd0, 1'b1));
        chk("sub_valE", bus.valE, 64'd0);
        @(posedge clk); #1;
        chk("sub_zf", {63'd0, bus.zf}, 64'd1);
        chk("sub_of", {63'd0, bus.of}, 64'd0);
        apply(64'd0, enc(8'h73, 8'h00, 64'd0, 1'b0));
        chk("sub_je", {63'd0, bus.cnd}, 64'd1);
        apply(64'd0, enc(8'h74, 8'h00, 64'd0, 1'b0));
        chk("sub_jne", {63'd0, bus.cnd}, 64'd0);
        apply(64'd0, enc(8'h71, 8'h00, 64'd0, 1'b0));
        chk("sub_jle", {63'd0, bus.cnd}, 64'd1);

        // stack ops and write-port priority
        apply(64'd0, enc(8'h10, 8'h00, 64'd0, 1'b0));
        wr(4'h4, 64'd64, 4'hF, 64'd0);
        apply(64'd0, enc(8'hA0, 8'h0F, 64'd0, 1'b1));
        chk("push_valE", bus.valE, 64'd56);
        apply(64'd0, enc(8'hB0, 8'h0F, 64'd0, 1'b1));
        chk("pop_valA", bus.valA, 64'd64);
        chk("pop_valB", bus.valB, 64'd64);
        chk("pop_valE", bus.valE, 64'd72);
        wr(4'h4, 64'd72, 4'h4, 64'h99);
        chk("wb_prio_rsp", bus.valA, 64'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
